// File: rtl/edge_pkg.sv
// Shared definitions for the edge-kernel output packer.
//   pixel_t    one 8-bit result pixel
//   pix_bus_t  one 8-pixel beat; lane i sits in bits [8*i +: 8]
//   beat_t     beat as stored in the output FIFO: pixels plus framing flags
package edge_pkg;

    localparam int unsigned LANES = 8;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [LANES-1:0] pix_bus_t;

    typedef struct packed {
        pix_bus_t pix;
        logic     sof;
        logic     eol;
        logic     eof;
    } beat_t;

endpackage

// File: rtl/pix_beat_fifo.sv
// First-word-fall-through FIFO holding masked beats with their framing flags.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored while full)
//   push_data    beat to store
//   pop          drop the head beat (ignored while empty)
//   head         oldest stored beat; all zero while empty
//   full, empty  occupancy status
module pix_beat_fifo
    import edge_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  beat_t push_data,
    input  logic  pop,
    output beat_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    beat_t       mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/edge_out_packer.sv
// Output packer for 8-pixel edge-kernel result beats. Tracks raster position,
// zeroes the invalid kernel border, tags SOF/EOL/EOF and buffers beats in a
// small FIFO presented as a valid/ready stream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_pix          8 result pixels; lane i is column col_beat*8+i
//   in_valid        in_pix valid
//   in_sof          beat is row 0, col_beat 0 (forces resync)
//   in_ready        packer can accept a beat (FIFO not full)
//   out_pix         masked pixels of the head beat (0 when idle)
//   out_valid       head beat valid
//   out_ready       downstream accepts the head beat
//   out_sof/eol/eof framing flags of the head beat (0 when idle)
//   frame_done      one-cycle pulse after an EOF beat is popped
//   err_misalign    sticky: in_sof seen away from position (0,0)
module edge_out_packer
    import edge_pkg::*;
#(
    parameter int unsigned W      = 3120,
    parameter int unsigned H      = 2084,
    parameter int unsigned BORDER = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  pix_bus_t in_pix,
    input  logic     in_valid,
    input  logic     in_sof,
    output logic     in_ready,
    output pix_bus_t out_pix,
    output logic     out_valid,
    input  logic     out_ready,
    output logic     out_sof,
    output logic     out_eol,
    output logic     out_eof,
    output logic     frame_done,
    output logic     err_misalign
);

    localparam int unsigned BEATS = W / LANES;
    localparam int unsigned CBW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RW    = (H > 1) ? $clog2(H) : 1;

    logic [CBW-1:0] col_beat;
    logic [RW-1:0]  row;
    logic [CBW-1:0] beat_col;
    logic [RW-1:0]  beat_row;
    logic           last_col;
    logic           last_row;
    logic           accept;
    logic           row_ok;
    int unsigned    row_pos;
    int unsigned    col_pos;
    beat_t          push_beat;
    beat_t          head;
    logic           full;
    logic           empty;

    assign in_ready = !full;
    assign accept   = in_valid && !full;

    // The accepted beat's position: in_sof overrides the tracked position.
    always_comb begin
        beat_col  = in_sof ? '0 : col_beat;
        beat_row  = in_sof ? '0 : row;
        last_col  = (beat_col == CBW'(BEATS - 1));
        last_row  = (beat_row == RW'(H - 1));
        row_pos   = 32'(beat_row);
        row_ok    = (row_pos >= BORDER) && (row_pos < H - BORDER);
        col_pos   = 0;
        push_beat = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            col_pos = 32'(beat_col) * LANES + i;
            if (row_ok && (col_pos >= BORDER) && (col_pos < W - BORDER))
                push_beat.pix[i] = in_pix[i];
            else
                push_beat.pix[i] = '0;
        end
        push_beat.sof = (beat_col == '0) && (beat_row == '0);
        push_beat.eol = last_col;
        push_beat.eof = last_col && last_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_beat     <= '0;
            row          <= '0;
            err_misalign <= 1'b0;
        end else if (accept) begin
            if (last_col) begin
                col_beat <= '0;
                row      <= last_row ? '0 : beat_row + 1'b1;
            end else begin
                col_beat <= beat_col + 1'b1;
                row      <= beat_row;
            end
            if (in_sof && ((col_beat != '0) || (row != '0)))
                err_misalign <= 1'b1;
        end
    end

    pix_beat_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_data(push_beat),
        .pop      (out_ready),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign out_valid = !empty;
    assign out_pix   = head.pix;
    assign out_sof   = head.sof;
    assign out_eol   = head.eol;
    assign out_eof   = head.eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= out_valid && out_ready && head.eof;
    end

endmodule

// File: tb/tb_edge_out_packer.sv
module tb_edge_out_packer;
    import edge_pkg::*;

    localparam int unsigned TW    = 16;
    localparam int unsigned TH    = 6;
    localparam int unsigned TBRD  = 2;
    localparam int unsigned TD    = 4;
    localparam int unsigned BEATS = TW / 8;
    localparam int unsigned FRAME = BEATS * TH;

    logic     clk = 1'b0;
    logic     rst_n = 1'b1;
    pix_bus_t in_pix = '0;
    logic     in_valid = 1'b0;
    logic     in_sof = 1'b0;
    logic     in_ready;
    pix_bus_t out_pix;
    logic     out_valid;
    logic     out_ready = 1'b0;
    logic     out_sof;
    logic     out_eol;
    logic     out_eof;
    logic     frame_done;
    logic     err_misalign;

    edge_out_packer #(
        .W(TW), .H(TH), .BORDER(TBRD), .DEPTH(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .out_pix(out_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done),
        .err_misalign(err_misalign)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Reference model: beat index within the frame plus an expected-beat queue.
    beat_t       q[$];
    int unsigned idx = 0;
    logic        err_exp = 1'b0;
    logic        fd_exp = 1'b0;

    // Observations of the DUT.
    pix_bus_t    pop_pix[$];
    logic        pop_sof[$];
    logic        pop_eol[$];
    int unsigned fd_count = 0;
    int unsigned pops_obs = 0;
    logic        ir_obs;
    pix_bus_t    head_obs;
    logic        track_frames = 1'b0;
    int unsigned sofs_seen = 0;
    logic        prev_eof_obs = 1'b0;

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic s, input pix_bus_t p);
        int unsigned pos, r, cb, col;
        beat_t b;
        pos = s ? 0 : idx;
        if (s && idx != 0) err_exp = 1'b1;
        r  = pos / BEATS;
        cb = pos % BEATS;
        for (int unsigned i = 0; i < 8; i++) begin
            col = cb * 8 + i;
            if (col < TBRD || col >= TW - TBRD || r < TBRD || r >= TH - TBRD)
                b.pix[i] = 8'h00;
            else
                b.pix[i] = p[i];
        end
        b.sof = (pos == 0);
        b.eol = (cb == BEATS - 1);
        b.eof = (pos == FRAME - 1);
        q.push_back(b);
        idx = (pos + 1) % FRAME;
    endtask

    // One clock cycle: drive, sample at the falling edge, compare, update model.
    task automatic cycle(input logic v, input logic s, input pix_bus_t p, input logic r,
                         output logic acc);
        logic pop;
        in_valid  = v;
        in_sof    = s;
        in_pix    = p;
        out_ready = r;
        @(negedge clk);
        ir_obs   = in_ready;
        head_obs = out_pix;
        check("in_ready", in_ready, q.size() < TD);
        check("frame_done", frame_done, fd_exp);
        check("err_misalign", err_misalign, err_exp);
        if (q.size() != 0) begin
            check("out_valid", out_valid, 1'b1);
            check("out_beat", {out_pix, out_sof, out_eol, out_eof}, q[0]);
        end else begin
            check("out_valid", out_valid, 1'b0);
            check("idle_beat", {out_pix, out_sof, out_eol, out_eof}, '0);
        end
        if (frame_done) fd_count++;
        if (out_valid && out_ready) begin
            pops_obs++;
            pop_pix.push_back(out_pix);
            pop_sof.push_back(out_sof);
            pop_eol.push_back(out_eol);
            if (track_frames && out_sof) begin
                if (sofs_seen > 0) check("sof_after_eof", prev_eof_obs, 1'b1);
                sofs_seen++;
            end
            prev_eof_obs = out_eof;
        end
        acc = v && (q.size() < TD);
        pop = r && (q.size() != 0);
        fd_exp = pop && q[0].eof;
        if (pop) void'(q.pop_front());
        if (acc) model_push(s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input pix_bus_t p, input logic r);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 64 && !acc; n++)
            cycle(1'b1, s, p, (n == 0) ? r : 1'b1, acc);
        check("send_timeout", acc, 1'b1);
    endtask

    task automatic drain();
        logic acc;
        for (int n = 0; n < 64 && q.size() != 0; n++)
            cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check("drain_empty", out_valid, 1'b0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_beat", {out_pix, out_sof, out_eol, out_eof}, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err_misalign, 1'b0);
        q.delete();
        idx = 0;
        err_exp = 1'b0;
        fd_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic pix_bus_t rnd_pix();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic     acc;
        int       nacc;
        pix_bus_t stall_pix;
        pix_bus_t pend;
        pix_bus_t ones;

        ones = '1;
        @(posedge clk);
        #1;
        do_reset();

        // 1: full frame of 0xFF, continuous ready
        pop_pix.delete(); pop_sof.delete(); pop_eol.delete();
        fd_count = 0;
        for (int k = 0; k < 12; k++) send(k == 0, ones, 1'b1);
        drain();
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check("t1_pops", pop_pix.size(), 12);
        check("t1_row0", pop_pix[0], 64'h0);
        check("t1_row2_b0", pop_pix[4], 64'hFFFF_FFFF_FFFF_0000);
        check("t1_row2_b1", pop_pix[5], 64'h0000_FFFF_FFFF_FFFF);
        check("t1_row3_b1", pop_pix[7], 64'h0000_FFFF_FFFF_FFFF);
        check("t1_row4", pop_pix[8], 64'h0);
        check("t1_eol_b1", pop_eol[1], 1'b1);
        check("t1_eol_b2", pop_eol[2], 1'b0);
        check("t1_frame_done_count", fd_count, 1);

        // 2: stall downstream, five pushes
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            pend = rnd_pix();
            cycle(1'b1, 1'b0, pend, 1'b0, acc);
            if (in_valid && ir_obs) nacc++;
            if (k == 1) stall_pix = head_obs;
        end
        check("t2_accepts", nacc, 4);
        check("t2_full_in_ready", ir_obs, 1'b0);
        check("t2_stall_stable", head_obs, stall_pix);
        send(1'b0, pend, 1'b1);
        drain();

        // 3: simultaneous push/pop at count 2
        pops_obs = 0;
        send(1'b0, rnd_pix(), 1'b0);
        send(1'b0, rnd_pix(), 1'b0);
        nacc = 0;
        for (int k = 0; k < 22; k++) begin
            cycle(1'b1, 1'b0, rnd_pix(), 1'b1, acc);
            if (ir_obs) nacc++;
        end
        check("t3_in_ready_all", nacc, 22);
        check("t3_pops_steady", pops_obs, 22);
        check("t3_held", out_valid, 1'b1);
        drain();
        check("t3_pops_total", pops_obs, 24);

        // 4: mid-frame resync
        do_reset();
        pop_pix.delete(); pop_sof.delete(); pop_eol.delete();
        for (int k = 0; k < 11; k++)
            send(k == 4, ones, ($urandom_range(0, 3) != 0));
        drain();
        check("t4_err", err_misalign, 1'b1);
        check("t4_sof_first", pop_sof[0], 1'b1);
        check("t4_sof_beat5", pop_sof[4], 1'b1);
        check("t4_beat5_row0", pop_pix[4], 64'h0);
        check("t4_beat9_row2", pop_pix[8], 64'hFFFF_FFFF_FFFF_0000);
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b1, acc);
        check("t4_err_sticky", err_misalign, 1'b1);

        // 5: reset with three beats held
        for (int k = 0; k < 3; k++) send(1'b0, rnd_pix(), 1'b0);
        check("t5_held", out_valid, 1'b1);
        do_reset();
        pop_sof.delete();
        send(1'b0, ones, 1'b1);
        drain();
        check("t5_sof_after_reset", pop_sof[0], 1'b1);

        // 6: two frames back to back with input gaps
        do_reset();
        fd_count = 0;
        track_frames = 1'b1;
        sofs_seen = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 12; k++) begin
                if ($urandom_range(0, 2) == 0)
                    cycle(1'b0, 1'b0, '0, ($urandom_range(0, 1) != 0), acc);
                send(k == 0, rnd_pix(), ($urandom_range(0, 3) != 0));
            end
        end
        drain();
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, acc);
        track_frames = 1'b0;
        check("t6_sofs", sofs_seen, 2);
        check("t6_frame_done_count", fd_count, 2);
        check("t6_no_err", err_misalign, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
